// File: rtl/register_file.sv
// 32 x 64-bit architectural register file feeding the ALU operands.
// Two bypassed read ports with a registered output stage, one write port, X31 reads as zero.
module register_file #(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   input  logic                     stall,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_a,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_b,
   output logic [WIDTH-1:0]         a_out,
   output logic [WIDTH-1:0]         b_out,
   output logic                     out_valid
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0] wr_sel_c;

   logic [WIDTH-1:0] rd_a_c;
   logic [WIDTH-1:0] rd_b_c;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] b_d;
   logic             valid_q;
   logic             valid_d;

   // Zero register wins over bypass, bypass wins over stored contents.
   function automatic logic [WIDTH-1:0] read_port(
      input logic [AW-1:0] addr
   );
      logic [WIDTH-1:0] val;
      if (addr == ZERO_ADDR) begin
         val = '0;
      end else if (wr_en && (wr_addr == addr)) begin
         val = wr_data;
      end else begin
         val = regs_q[addr];
      end
      return val;
   endfunction

   always_comb begin
      wr_sel_c = '0;
      if (wr_en && (wr_addr != ZERO_ADDR)) begin
         wr_sel_c[wr_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (wr_sel_c[i]) begin
               regs_q[i] <= wr_data;
            end
         end
      end
   end

   always_comb begin
      rd_a_c = read_port(rd_addr_a);
      rd_b_c = read_port(rd_addr_b);
   end

   // Output stage: stall freezes everything; an idle cycle keeps data but clears valid.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      valid_d = valid_q;
      if (!stall) begin
         if (rd_en) begin
            a_d     = rd_a_c;
            b_d     = rd_b_c;
            valid_d = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         valid_q <= valid_d;
      end
   end

   assign a_out     = a_q;
   assign b_out     = b_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, write/read, bypass,
// zero register, stall and a full streaming sweep.
module tb_register_file;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic        rd_en;
   logic        stall;
   logic [4:0]  rd_addr_a;
   logic [4:0]  rd_addr_b;
   logic [63:0] a_out;
   logic [63:0] b_out;
   logic        out_valid;

   int total;
   int bad;

   register_file dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .stall     (stall),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .a_out     (a_out),
      .b_out     (b_out),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                        input logic re, input logic [4:0] ra, input logic [4:0] rb,
                        input logic st);
      wr_en = we; wr_addr = wa; wr_data = wd;
      rd_en = re; rd_addr_a = ra; rd_addr_b = rb; stall = st;
   endtask

   logic [63:0] exp_a;
   logic [63:0] exp_b;

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 1'b0);
      #3;
      check("reset_a", a_out, 64'h0);
      check("reset_b", b_out, 64'h0);
      check("reset_valid", 64'(out_valid), 64'h0);
      step();
      #2 rst = 1'b0;

      // Load X5 and read it back before a mid-cycle reset.
      drive(1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 5'd0, 1'b0);
      step();
      drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 5'd5, 1'b0);
      step();
      check("pre_rst_a", a_out, 64'hDEAD);
      check("pre_rst_valid", 64'(out_valid), 64'h1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_a", a_out, 64'h0);
      check("async_rst_b", b_out, 64'h0);
      check("async_rst_valid", 64'(out_valid), 64'h0);
      step();
      #2 rst = 1'b0;
      step();
      check("post_rst_x5", a_out, 64'h0);
      check("post_rst_valid", 64'(out_valid), 64'h1);

      // Write then read on the following edge.
      drive(1'b1, 5'd3, 64'h0123_4567_89AB_CDEF, 1'b0, 5'd0, 5'd0, 1'b0);
      step();
      check("idle_valid", 64'(out_valid), 64'h0);
      drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 5'd3, 1'b0);
      step();
      check("wr_rd_a", a_out, 64'h0123_4567_89AB_CDEF);
      check("wr_rd_b", b_out, 64'h0123_4567_89AB_CDEF);
      check("wr_rd_valid", 64'(out_valid), 64'h1);

      // Same-edge bypass on A, stored value on B.
      drive(1'b1, 5'd8, 64'h42, 1'b0, 5'd0, 5'd0, 1'b0);
      step();
      check("idle_hold_a", a_out, 64'h0123_4567_89AB_CDEF);
      drive(1'b1, 5'd7, 64'hFFFF_0000_FFFF_0000, 1'b1, 5'd7, 5'd8, 1'b0);
      step();
      check("bypass_a", a_out, 64'hFFFF_0000_FFFF_0000);
      check("bypass_b", b_out, 64'h42);

      // Bypass to both ports at once.
      drive(1'b1, 5'd9, 64'h9999, 1'b1, 5'd9, 5'd9, 1'b0);
      step();
      check("bypass_both_a", a_out, 64'h9999);
      check("bypass_both_b", b_out, 64'h9999);

      // Zero register beats bypass, and the write is dropped.
      drive(1'b1, 5'd31, 64'h55, 1'b1, 5'd31, 5'd7, 1'b0);
      step();
      check("zero_bypass_a", a_out, 64'h0);
      check("zero_other_b", b_out, 64'hFFFF_0000_FFFF_0000);
      drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd31, 5'd31, 1'b0);
      step();
      check("zero_later_a", a_out, 64'h0);
      check("zero_later_b", b_out, 64'h0);

      // Stall freezes the output stage while writes still land.
      drive(1'b1, 5'd1, 64'h11, 1'b0, 5'd0, 5'd0, 1'b0);
      step();
      drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd1, 5'd3, 1'b0);
      step();
      check("stall_cap_a", a_out, 64'h11);
      drive(1'b1, 5'd1, 64'h22, 1'b1, 5'd1, 5'd1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_hold_a", a_out, 64'h11);
         check("stall_hold_b", b_out, 64'h0123_4567_89AB_CDEF);
         check("stall_hold_valid", 64'(out_valid), 64'h1);
      end
      drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd1, 5'd1, 1'b0);
      step();
      check("post_stall_a", a_out, 64'h22);
      check("post_stall_valid", 64'(out_valid), 64'h1);
      drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 1'b1);
      step();
      check("stall_idle_valid", 64'(out_valid), 64'h1);

      // Streaming sweep.
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 5'(i), 64'(i) * 64'h1000, 1'b0, 5'd0, 5'd0, 1'b0);
         step();
      end
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 64'h0, 1'b1, 5'(i), 5'(31 - i), 1'b0);
         step();
         exp_a = (i == 31) ? 64'h0 : 64'(i) * 64'h1000;
         exp_b = (i == 0) ? 64'h0 : 64'(31 - i) * 64'h1000;
         check("stream_a", a_out, exp_a);
         check("stream_b", b_out, exp_b);
         check("stream_valid", 64'(out_valid), 64'h1);
      end

      drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 1'b0);
      step();
      check("end_idle_valid", 64'(out_valid), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
